booth_ctrl: RTL and testbench
=============================

Name: booth_ctrl

Overview:
- Control FSM for the 8-bit Booth multiplier datapath; sits directly upstream of it.
- On a start request it sequences the datapath strobes (load, add_en, sub_en, shift_en, count_en) from the datapath's current Q[0]/Q-1 bits.
- Keeps its own iteration count and raises a one-cycle product_valid when the product register holds the final result.
- Consumers (ALU result mux) sample the datapath product on product_valid.

Parameters:
- ITER, 8, number of Booth iterations (multiplier width).
- CNT_W, 4, iteration counter width; must satisfy 2^CNT_W > ITER.

Ports:
- clk  input  1  system clock, rising edge.
- reset  input  1  synchronous, active-high reset.
- start  input  1  request a multiply; sampled only in IDLE.
- q_lsb  input  1  datapath Q[0] (current multiplier LSB).
- q_m1  input  1  datapath Q-1 bit.
- load  output  1  datapath load strobe.
- add_en  output  1  datapath add strobe (A := A + M).
- sub_en  output  1  datapath subtract strobe (A := A - M).
- shift_en  output  1  datapath arithmetic right shift strobe.
- count_en  output  1  datapath counter enable; mirrors shift_en.
- busy  output  1  high in every state except IDLE.
- product_valid  output  1  one-cycle pulse; datapath product is final.

Behaviour:
- One clock (clk). Reset is synchronous and active-high (reset).
- All outputs are Moore, decoded from state only, except the EVAL branch decision. All outputs are registered-state decodes, so no combinational path runs from q_lsb/q_m1 to the outputs.
- Reset: state=IDLE, iter counter=0, all outputs 0. Reset asserted mid-operation aborts on the next edge with the same values; the datapath contents are left as-is.
- States and transitions:
  - IDLE: all strobes 0, busy=0. If start=1 -> LOAD, else stay.
  - LOAD: load=1 for exactly one cycle; iter counter cleared to 0 -> EVAL.
  - EVAL: no strobes. Decode {q_lsb,q_m1} sampled this cycle: 2'b10 -> SUB; 2'b01 -> ADD; 2'b00 or 2'b11 -> SHIFT.
  - ADD: add_en=1, sub_en=0, one cycle -> SHIFT.
  - SUB: sub_en=1, add_en=0, one cycle -> SHIFT.
  - SHIFT: shift_en=1 and count_en=1, one cycle.
    - If iter==ITER-1 -> DONE, else iter := iter+1 -> EVAL.
  - DONE: product_valid=1, busy=1, one cycle -> IDLE.
- Strobe exclusivity: at most one of load/add_en/sub_en/shift_en is high in any cycle. add_en and sub_en are never both high.
- start is ignored outside IDLE, including during the DONE cycle. There is no queuing. A start held high continuously restarts immediately after DONE->IDLE, with a 1-cycle IDLE gap.
- Latency: start sampled in IDLE at cycle 0 -> LOAD at cycle 1 -> product_valid at cycle 2 + 2*ITER + N_ops, where N_ops is the number of ADD/SUB visits. With ITER=8 the range is 18 (no ops) to 26 (an op every iteration).
- The iter counter never wraps in normal operation. It is cleared in LOAD and saturates logically at ITER-1 via the DONE transition.
- q_lsb/q_m1 are only meaningful in EVAL and are don't-care in all other states.

Test Plan:
- Reset, then idle 5 cycles with start=0 -> busy=0, all strobes 0, product_valid never asserted.
- start pulse, datapath multiplier=0x00 (q_lsb=q_m1=0 throughout) -> load at cycle 1, 8 EVAL/SHIFT pairs, no add_en/sub_en, product_valid exactly at cycle 18, busy low at cycle 19.
- multiplier=0x55 via bit-accurate datapath model -> pattern SUB, ADD, SUB, ADD, ... (4 sub_en and 4 add_en pulses), 8 shift_en pulses, product_valid at cycle 26; multiplicand 3 gives product 0x00FF.
- multiplier=0xFF -> one sub_en (iteration 0) then shifts only, product_valid at cycle 19. multiplier=0x01 -> sub_en then add_en, product_valid at cycle 20.
- start re-asserted during EVAL and during the DONE cycle -> ignored: no extra load, one product_valid. start held high -> second load exactly 2 cycles after first product_valid.
- reset asserted in cycle 7 of an active multiply -> next edge state=IDLE, busy=0, all strobes 0. Fresh start afterwards completes with normal latency.

Source files
------------

// File: rtl/booth_ctrl.sv
// booth_ctrl: sequencing FSM driving the load/add/sub/shift strobes of an 8-bit Booth multiplier datapath.
module booth_ctrl #(
  parameter int ITER  = 8,
  parameter int CNT_W = 4
) (
  input  logic clk,
  input  logic reset,
  input  logic start,
  input  logic q_lsb,
  input  logic q_m1,
  output logic load,
  output logic add_en,
  output logic sub_en,
  output logic shift_en,
  output logic count_en,
  output logic busy,
  output logic product_valid
);
  typedef enum logic [2:0] {IDLE, LOAD, EVAL, ADD, SUB, SHIFT, DONE} state_t;
  state_t state_q, state_d;
  logic [CNT_W-1:0] iter_q, iter_d;
  logic last;
  logic load_q, add_q, sub_q, shift_q, busy_q, valid_q;
  assign last = iter_q == CNT_W'(ITER - 1);
  always_comb begin
    state_d = state_q;
    iter_d  = iter_q;
    case (state_q)
      IDLE:     state_d = start ? LOAD : IDLE;
      LOAD: begin
        state_d = EVAL;
        iter_d  = '0;
      end
      EVAL:     state_d = (q_lsb ^ q_m1) ? (q_lsb ? SUB : ADD) : SHIFT;
      ADD, SUB: state_d = SHIFT;
      SHIFT: begin
        state_d = last ? DONE : EVAL;
        iter_d  = last ? iter_q : iter_q + 1'b1;
      end
      default:  state_d = IDLE;
    endcase
  end
  // Outputs are flopped decodes of the next state, so they track state_q with no path from q_lsb/q_m1.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      iter_q  <= '0;
      load_q  <= 1'b0;
      add_q   <= 1'b0;
      sub_q   <= 1'b0;
      shift_q <= 1'b0;
      busy_q  <= 1'b0;
      valid_q <= 1'b0;
    end else begin
      state_q <= state_d;
      iter_q  <= iter_d;
      load_q  <= state_d == LOAD;
      add_q   <= state_d == ADD;
      sub_q   <= state_d == SUB;
      shift_q <= state_d == SHIFT;
      busy_q  <= state_d != IDLE;
      valid_q <= state_d == DONE;
    end
  end
  assign load          = load_q;
  assign add_en        = add_q;
  assign sub_en        = sub_q;
  assign shift_en      = shift_q;
  assign count_en      = shift_q;
  assign busy          = busy_q;
  assign product_valid = valid_q;
endmodule

// File: tb/tb_booth_ctrl.sv
// tb_booth_ctrl: scoreboard bench for booth_ctrl driving a behavioural Booth datapath.
module tb_booth_ctrl;
  logic clk = 1'b0;
  logic rst, start, q_lsb, q_m1;
  logic load, add_en, sub_en, shift_en, count_en, busy, product_valid;
  typedef struct {
    int          lat;
    logic [15:0] prod;
    int          na;
    int          ns;
  } exp_t;
  exp_t sb[$];
  logic [7:0] a_r, q_r, m_r, mult;
  logic       qm1_r;
  int cyc = 0, errs = 0, checks = 0;
  int start_cyc = -100, pv_cyc = -1, held_pv = -1;
  int na = 0, ns = 0, nsh = 0;
  logic rst_d = 1'b0, held_mode = 1'b0, done_stim = 1'b0;
  booth_ctrl #(.ITER(8), .CNT_W(4)) dut (
    .clk(clk), .reset(rst), .start(start), .q_lsb(q_lsb), .q_m1(q_m1),
    .load(load), .add_en(add_en), .sub_en(sub_en), .shift_en(shift_en),
    .count_en(count_en), .busy(busy), .product_valid(product_valid)
  );
  always #5 clk = ~clk;
  assign q_lsb = q_r[0];
  assign q_m1  = qm1_r;
  always @(posedge clk) begin
    cyc   <= cyc + 1;
    rst_d <= rst;
    if (load) begin
      a_r   <= 8'h00;
      q_r   <= mult;
      qm1_r <= 1'b0;
    end else if (add_en) a_r <= a_r + m_r;
    else if (sub_en) a_r <= a_r - m_r;
    else if (shift_en) {a_r, q_r, qm1_r} <= {a_r[7], a_r, q_r};
  end
  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errs++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask
  always @(negedge clk) begin
    exp_t e;
    chk("strobe_excl", int'($countones({load, add_en, sub_en, shift_en}) > 1), 0);
    chk("count_mirror", int'(count_en), int'(shift_en));
    if (!busy) chk("idle_outputs", int'({load, add_en, sub_en, shift_en, count_en, product_valid}), 0);
    if (rst_d) begin
      chk("rst_busy", int'(busy), 0);
      chk("rst_outputs", int'({load, add_en, sub_en, shift_en, count_en, product_valid}), 0);
      start_cyc = -100;
      na = 0; ns = 0; nsh = 0;
    end else begin
      if (start && !busy) start_cyc = cyc;
      if (load) begin
        chk("load_latency", cyc, start_cyc + 1);
        if (held_mode && held_pv >= 0) chk("restart_gap", cyc, held_pv + 2);
        na = 0; ns = 0; nsh = 0;
      end
      if (add_en) na++;
      if (sub_en) ns++;
      if (shift_en) nsh++;
      if (product_valid) begin
        if (sb.size() == 0) chk("spurious_valid", 1, 0);
        else begin
          e = sb.pop_front();
          chk("valid_latency", cyc - start_cyc, e.lat);
          chk("product", int'({a_r, q_r}), int'(e.prod));
          chk("add_count", na, e.na);
          chk("sub_count", ns, e.ns);
          chk("shift_count", nsh, 8);
        end
        pv_cyc = cyc;
        if (held_mode) held_pv = cyc;
      end
      if (pv_cyc >= 0 && cyc == pv_cyc + 1) chk("busy_after_done", int'(busy), 0);
    end
    if (done_stim) begin
      chk("scoreboard_drained", sb.size(), 0);
      $display("Result: errors=%0d of %0d checks", errs, checks);
      $finish;
    end
  end
  task automatic run(input logic [7:0] mr, input logic [7:0] mc, input int lat,
                     input logic [15:0] prod, input int ea, input int es);
    m_r  = mc;
    mult = mr;
    sb.push_back('{lat, prod, ea, es});
    @(posedge clk) #1 start = 1'b1;
    @(posedge clk) #1 start = 1'b0;
    repeat (30) @(posedge clk);
  endtask
  initial begin
    rst = 1'b1; start = 1'b0; m_r = 8'h0; mult = 8'h0;
    a_r = 8'h0; q_r = 8'h0; qm1_r = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    repeat (5) @(posedge clk);
    run(8'h00, 8'h37, 18, 16'h0000, 0, 0);
    run(8'h55, 8'h03, 26, 16'h00FF, 4, 4);
    run(8'hFF, 8'h05, 19, 16'hFFFB, 0, 1);
    run(8'h01, 8'h07, 20, 16'h0007, 1, 1);
    // start pulsed again in EVAL (cycle 2) and in DONE (cycle 20): both ignored
    m_r = 8'h09; mult = 8'h02;
    sb.push_back('{20, 16'h0012, 1, 1});
    @(posedge clk) #1 start = 1'b1;
    @(posedge clk) #1 start = 1'b0;
    @(posedge clk) #1 start = 1'b1;
    @(posedge clk) #1 start = 1'b0;
    repeat (17) @(posedge clk);
    #1 start = 1'b1;
    @(posedge clk) #1 start = 1'b0;
    repeat (10) @(posedge clk);
    m_r = 8'h04; mult = 8'h03;
    sb.push_back('{20, 16'h000C, 1, 1});
    sb.push_back('{20, 16'h000C, 1, 1});
    held_mode = 1'b1;
    @(posedge clk) #1 start = 1'b1;
    repeat (22) @(posedge clk);
    #1 start = 1'b0;
    repeat (30) @(posedge clk);
    held_mode = 1'b0;
    m_r = 8'h03; mult = 8'h55;
    @(posedge clk) #1 start = 1'b1;
    @(posedge clk) #1 start = 1'b0;
    repeat (6) @(posedge clk);
    #1 rst = 1'b1;
    @(posedge clk) #1 rst = 1'b0;
    repeat (3) @(posedge clk);
    run(8'h55, 8'h03, 26, 16'h00FF, 4, 4);
    repeat (5) @(posedge clk);
    done_stim = 1'b1;
  end
  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end
endmodule
